// File: rtl/digitizer_pkg.sv
// Shared definitions for the digitizer: register offsets, register bit
// positions, the capture state encoding and a couple of small helpers.
package digitizer_pkg;

    // Register word indices, taken from byte address bits [3:2]
    localparam logic [1:0] REG_CTRL     = 2'd0;
    localparam logic [1:0] REG_STATUS   = 2'd1;
    localparam logic [1:0] REG_PKT_SIZE = 2'd2;
    localparam logic [1:0] REG_BEAT_CNT = 2'd3;

    // CTRL bit positions
    localparam int CTRL_RUN = 0;
    localparam int CTRL_SRC = 1;

    // STATUS bit positions
    localparam int STAT_BUSY     = 0;
    localparam int STAT_DONE     = 1;
    localparam int STAT_OVERFLOW = 2;

    // Each ADC sample occupies one 16-bit lane of an output beat
    localparam int SAMPLE_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    // Byte address to register word index; the low two bits do not select anything
    function automatic logic [1:0] reg_index(input logic [3:0] addr);
        return addr[3:2];
    endfunction

endpackage

// File: rtl/digitizer_packer.sv
// Packs pairs of samples into 32-bit beats and holds each beat in a single
// output register until the stream sink accepts it.
module digitizer_packer
    import digitizer_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADC_W  = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              abort,
    input  logic              sample_valid,
    input  logic [ADC_W-1:0]  sample,
    input  logic              beat_wanted,
    input  logic              beat_is_last,
    input  logic              tready,
    output logic [DATA_W-1:0] tdata,
    output logic              tvalid,
    output logic              tlast,
    output logic              beat_loaded,
    output logic              beat_dropped
);

    logic                half;
    logic [SAMPLE_W-1:0] low_lane;
    logic [SAMPLE_W-1:0] wide_sample;
    logic                pair_done;
    logic                slot_free;

    // A completed pair only becomes a beat while the packet still needs one;
    // an occupied output register turns it into an overflow instead.
    always_comb begin
        wide_sample  = {{(SAMPLE_W-ADC_W){1'b0}}, sample};
        pair_done    = sample_valid && half && !abort;
        slot_free    = !tvalid || tready;
        beat_loaded  = pair_done && beat_wanted && slot_free;
        beat_dropped = pair_done && beat_wanted && !slot_free;
    end

    // Track which half of the pair is next and remember the first sample
    always_ff @(posedge clk) begin
        if (rst || clear || abort) begin
            half     <= 1'b0;
            low_lane <= '0;
        end else if (sample_valid) begin
            half <= ~half;
            if (!half) begin
                low_lane <= wide_sample;
            end
        end
    end

    // Output beat register: emptied on acceptance, refilled on a new beat,
    // and marked last when an abort leaves a beat waiting to drain.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            tvalid <= 1'b0;
            tlast  <= 1'b0;
            tdata  <= '0;
        end else begin
            if (tvalid && tready) begin
                tvalid <= 1'b0;
                tlast  <= 1'b0;
            end
            if (beat_loaded) begin
                tvalid <= 1'b1;
                tlast  <= beat_is_last;
                tdata  <= {wide_sample, low_lane};
            end
            if (abort && tvalid && !tready) begin
                tlast <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/digitizer.sv
// Sample digitizer: register file and capture FSM feeding an AXI4-Stream
// master through the packer sub-module.
module digitizer
    import digitizer_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADC_W  = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADC_W-1:0]  adc_data,
    input  logic              adc_valid,
    input  logic              reg_wr,
    input  logic              reg_rd,
    input  logic [3:0]        reg_addr,
    input  logic [DATA_W-1:0] reg_wdata,
    output logic [DATA_W-1:0] reg_rdata,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              done_irq
);

    state_t              state;
    state_t              state_next;

    logic                ctrl_run;
    logic                ctrl_src;
    logic                status_done;
    logic                status_ovf;
    logic [DATA_W-1:0]   pkt_size;
    logic [DATA_W-1:0]   beat_cnt;
    logic [DATA_W-3:0]   beat_target;
    logic [DATA_W-3:0]   loaded_cnt;
    logic [ADC_W-1:0]    test_cnt;

    logic                busy;
    logic                wr_ctrl;
    logic                wr_status;
    logic                wr_pkt;
    logic                start;
    logic                abort;
    logic                finish;
    logic                beat_accept;
    logic                take_sample;
    logic [ADC_W-1:0]    sample;
    logic                beat_wanted;
    logic                beat_is_last;
    logic                beat_loaded;
    logic                beat_dropped;
    logic [DATA_W-1:0]   rd_word;
    logic [1:0]          unused_addr_bits;

    assign unused_addr_bits = reg_addr[1:0];

    // Register write decode and stream handshake
    always_comb begin
        busy        = (state != IDLE);
        wr_ctrl     = reg_wr && (reg_index(reg_addr) == REG_CTRL);
        wr_status   = reg_wr && (reg_index(reg_addr) == REG_STATUS);
        wr_pkt      = reg_wr && (reg_index(reg_addr) == REG_PKT_SIZE);
        beat_accept = m_axis_tvalid && m_axis_tready;
    end

    // Next-state logic; completion of the final beat wins over a same-cycle abort
    always_comb begin
        state_next = state;
        start      = 1'b0;
        abort      = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (wr_ctrl && reg_wdata[CTRL_RUN] && (pkt_size[DATA_W-1:2] != '0)) begin
                    start      = 1'b1;
                    state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                if (beat_accept && m_axis_tlast) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end else if (wr_ctrl && !reg_wdata[CTRL_RUN]) begin
                    abort      = 1'b1;
                    state_next = (m_axis_tvalid && !m_axis_tready) ? DRAIN : IDLE;
                end
            end
            DRAIN: begin
                if (!m_axis_tvalid || m_axis_tready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Capture state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Sample selection; once the last beat is loaded further pairs are discarded
    always_comb begin
        take_sample  = (state == CAPTURE) && adc_valid && !abort;
        sample       = ctrl_src ? adc_data : test_cnt;
        beat_wanted  = (loaded_cnt != beat_target);
        beat_is_last = (loaded_cnt == beat_target - 1'b1);
    end

    // CTRL: SRC follows every CTRL write, RUN only rises on an accepted start
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_run <= 1'b0;
            ctrl_src <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ctrl_src <= reg_wdata[CTRL_SRC];
            end
            if (start) begin
                ctrl_run <= 1'b1;
            end else if (finish || abort || state_next == IDLE) begin
                ctrl_run <= 1'b0;
            end
        end
    end

    // STATUS sticky bits: set by events, cleared by write-one or a new start
    always_ff @(posedge clk) begin
        if (rst) begin
            status_done <= 1'b0;
            status_ovf  <= 1'b0;
        end else if (start) begin
            status_done <= 1'b0;
            status_ovf  <= 1'b0;
        end else begin
            if (finish) begin
                status_done <= 1'b1;
            end else if (wr_status && reg_wdata[STAT_DONE]) begin
                status_done <= 1'b0;
            end
            if (beat_dropped) begin
                status_ovf <= 1'b1;
            end else if (wr_status && reg_wdata[STAT_OVERFLOW]) begin
                status_ovf <= 1'b0;
            end
        end
    end

    // Packet size register, writable at any time; the target is latched at start
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_size <= '0;
        end else if (wr_pkt) begin
            pkt_size <= reg_wdata;
        end
    end

    // Beat bookkeeping: target, beats loaded into the output register, beats sent
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_target <= '0;
            loaded_cnt  <= '0;
            beat_cnt    <= '0;
        end else if (start) begin
            beat_target <= pkt_size[DATA_W-1:2];
            loaded_cnt  <= '0;
            beat_cnt    <= '0;
        end else begin
            if (beat_loaded) begin
                loaded_cnt <= loaded_cnt + 1'b1;
            end
            if (beat_accept) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

    // Test pattern counter advances on every taken sample, whatever the source
    always_ff @(posedge clk) begin
        if (rst || start) begin
            test_cnt <= '0;
        end else if (take_sample) begin
            test_cnt <= test_cnt + 1'b1;
        end
    end

    // Completion interrupt is a single-cycle pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            done_irq <= 1'b0;
        end else begin
            done_irq <= finish;
        end
    end

    // Read mux built from current register state, so a same-cycle write is not visible
    always_comb begin
        rd_word = '0;
        case (reg_index(reg_addr))
            REG_CTRL: begin
                rd_word[CTRL_RUN] = ctrl_run;
                rd_word[CTRL_SRC] = ctrl_src;
            end
            REG_STATUS: begin
                rd_word[STAT_BUSY]     = busy;
                rd_word[STAT_DONE]     = status_done;
                rd_word[STAT_OVERFLOW] = status_ovf;
            end
            REG_PKT_SIZE: rd_word = pkt_size;
            REG_BEAT_CNT: rd_word = beat_cnt;
            default:      rd_word = '0;
        endcase
    end

    // Registered read data, updated only by a read strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_rdata <= '0;
        end else if (reg_rd) begin
            reg_rdata <= rd_word;
        end
    end

    digitizer_packer #(
        .DATA_W(DATA_W),
        .ADC_W (ADC_W)
    ) u_packer (
        .clk         (clk),
        .rst         (rst),
        .clear       (start),
        .abort       (abort),
        .sample_valid(take_sample),
        .sample      (sample),
        .beat_wanted (beat_wanted),
        .beat_is_last(beat_is_last),
        .tready      (m_axis_tready),
        .tdata       (m_axis_tdata),
        .tvalid      (m_axis_tvalid),
        .tlast       (m_axis_tlast),
        .beat_loaded (beat_loaded),
        .beat_dropped(beat_dropped)
    );

endmodule

// File: tb/tb_digitizer.sv
// Self-checking bench for the digitizer: a sample-level model pushes expected
// beats into a scoreboard, and a stream monitor pops and compares them.
module tb_digitizer;

    localparam logic [3:0] A_CTRL   = 4'h0;
    localparam logic [3:0] A_STATUS = 4'h4;
    localparam logic [3:0] A_PKT    = 4'h8;
    localparam logic [3:0] A_BEAT   = 4'hC;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic        clk;
    logic        rst;
    logic [11:0] adc_data;
    logic        adc_valid;
    logic        reg_wr;
    logic        reg_rd;
    logic [3:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        done_irq;

    int          checkCount = 0;
    int          passCount  = 0;
    int          irqCount   = 0;
    int          rxBeats    = 0;
    logic [31:0] wrapBeat   = '0;
    beat_t       sb[$];
    beat_t       expBeat;

    int          mdlIdx;
    int          mdlTarget;
    logic        mdlHalf;
    logic [11:0] mdlCount;
    logic [15:0] mdlLow;

    logic [31:0] rd;

    digitizer #(.DATA_W(32), .ADC_W(12)) dut (
        .clk          (clk),
        .rst          (rst),
        .adc_data     (adc_data),
        .adc_valid    (adc_valid),
        .reg_wr       (reg_wr),
        .reg_rd       (reg_rd),
        .reg_addr     (reg_addr),
        .reg_wdata    (reg_wdata),
        .reg_rdata    (reg_rdata),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast),
        .done_irq     (done_irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Stream monitor: a handshake seen here completes at the next rising edge
    always @(negedge clk) begin
        if (!rst && m_axis_tvalid && m_axis_tready) begin
            if (rxBeats == 2048) wrapBeat = m_axis_tdata;
            rxBeats++;
            if (sb.size() == 0) begin
                checkOutput("beat expected by scoreboard", 32'(sb.size()), 32'd1);
            end else begin
                expBeat = sb.pop_front();
                checkOutput("beat tdata", m_axis_tdata, expBeat.data);
                checkOutput("beat tlast", 32'(m_axis_tlast), 32'(expBeat.last));
            end
        end
    end

    always @(negedge clk) begin
        if (done_irq) irqCount++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic regWrite(input logic [3:0] addr, input logic [31:0] data);
        reg_addr  = addr;
        reg_wdata = data;
        reg_wr    = 1'b1;
        tick();
        reg_wr    = 1'b0;
    endtask

    task automatic regRead(input logic [3:0] addr, output logic [31:0] data);
        reg_addr = addr;
        reg_rd   = 1'b1;
        tick();
        reg_rd   = 1'b0;
        data     = reg_rdata;
    endtask

    task automatic modelStart(input int target);
        mdlIdx    = 0;
        mdlTarget = target;
        mdlHalf   = 1'b0;
        mdlCount  = '0;
        rxBeats   = 0;
    endtask

    // Drive one sample strobe and advance the model; completed pairs become expected beats
    task automatic applyStimulus(input logic [11:0] adcSample, input logic useAdc, input logic dropBeat);
        logic [11:0] value;
        beat_t       b;
        value     = useAdc ? adcSample : mdlCount;
        mdlCount  = mdlCount + 12'd1;
        adc_data  = adcSample;
        adc_valid = 1'b1;
        tick();
        adc_valid = 1'b0;
        if (!mdlHalf) begin
            mdlLow  = {4'h0, value};
            mdlHalf = 1'b1;
        end else begin
            mdlHalf = 1'b0;
            if (!dropBeat) begin
                b.data = {4'h0, value, mdlLow};
                b.last = (mdlIdx == mdlTarget - 1);
                sb.push_back(b);
                mdlIdx++;
            end
        end
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) tick();
        checkOutput("scoreboard drained", 32'(sb.size()), 32'd0);
        repeat (3) tick();
    endtask

    initial begin
        beat_t b;
        rst = 1'b1; adc_data = '0; adc_valid = 1'b0; reg_wr = 1'b0; reg_rd = 1'b0;
        reg_addr = '0; reg_wdata = '0; m_axis_tready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        checkOutput("reset rdata", reg_rdata, 32'd0);
        checkOutput("reset tvalid", 32'(m_axis_tvalid), 32'd0);
        checkOutput("reset done_irq", 32'(done_irq), 32'd0);
        regRead(A_CTRL, rd);   checkOutput("reset CTRL", rd, 32'd0);
        regRead(A_STATUS, rd); checkOutput("reset STATUS", rd, 32'd0);
        regRead(A_PKT, rd);    checkOutput("reset PKT_SIZE", rd, 32'd0);
        regRead(A_BEAT, rd);   checkOutput("reset BEAT_CNT", rd, 32'd0);

        // Test-counter mode long enough to see the 12-bit wrap
        $display("[TB] test counter run with wrap");
        regWrite(A_PKT, 32'd8200);
        modelStart(2050);
        regWrite(A_CTRL, 32'd1);
        for (int i = 0; i < 4100; i++) begin
            applyStimulus(12'($urandom), 1'b0, 1'b0);
            tick();
        end
        waitDrain();
        checkOutput("wrap beat 2048", wrapBeat, 32'h0001_0000);
        regRead(A_STATUS, rd); checkOutput("test STATUS done", rd, 32'h2);
        regRead(A_CTRL, rd);   checkOutput("test CTRL run cleared", rd, 32'h0);
        regRead(A_BEAT, rd);   checkOutput("test BEAT_CNT", rd, 32'd2050);
        checkOutput("test irq count", 32'(irqCount), 32'd1);

        // ADC source, two beats
        $display("[TB] ADC run");
        regWrite(A_PKT, 32'd8);
        modelStart(2);
        regWrite(A_CTRL, 32'd3);
        regRead(A_STATUS, rd); checkOutput("adc STATUS busy only", rd, 32'h1);
        applyStimulus(12'hABC, 1'b1, 1'b0);
        applyStimulus(12'h123, 1'b1, 1'b0);
        applyStimulus(12'h456, 1'b1, 1'b0);
        applyStimulus(12'h789, 1'b1, 1'b0);
        waitDrain();
        checkOutput("adc irq count", 32'(irqCount), 32'd2);
        regRead(A_BEAT, rd);   checkOutput("adc BEAT_CNT", rd, 32'd2);

        // Backpressure: second beat completes while the first is held
        $display("[TB] backpressure");
        regWrite(A_PKT, 32'd16);
        modelStart(4);
        m_axis_tready = 1'b0;
        regWrite(A_CTRL, 32'd3);
        applyStimulus(12'h011, 1'b1, 1'b0);
        applyStimulus(12'h022, 1'b1, 1'b0);
        applyStimulus(12'h033, 1'b1, 1'b1);
        applyStimulus(12'h044, 1'b1, 1'b1);
        repeat (3) tick();
        checkOutput("held tvalid", 32'(m_axis_tvalid), 32'd1);
        checkOutput("held tdata", m_axis_tdata, sb[0].data);
        regRead(A_STATUS, rd); checkOutput("bp STATUS overflow", rd, 32'h5);
        m_axis_tready = 1'b1;
        tick();
        regRead(A_BEAT, rd);   checkOutput("bp BEAT_CNT after first", rd, 32'd1);
        applyStimulus(12'h055, 1'b1, 1'b0);
        applyStimulus(12'h066, 1'b1, 1'b0);
        applyStimulus(12'h077, 1'b1, 1'b0);
        applyStimulus(12'h088, 1'b1, 1'b0);
        applyStimulus(12'h099, 1'b1, 1'b0);
        applyStimulus(12'h0AA, 1'b1, 1'b0);
        waitDrain();
        regRead(A_BEAT, rd);   checkOutput("bp BEAT_CNT final", rd, 32'd4);
        regRead(A_STATUS, rd); checkOutput("bp STATUS done+ovf", rd, 32'h6);

        // Abort with a beat pending and a half-packed sample
        $display("[TB] abort");
        regWrite(A_PKT, 32'd64);
        modelStart(16);
        m_axis_tready = 1'b0;
        regWrite(A_CTRL, 32'd1);
        applyStimulus(12'h000, 1'b0, 1'b0);
        applyStimulus(12'h000, 1'b0, 1'b0);
        applyStimulus(12'h000, 1'b0, 1'b0);
        regWrite(A_CTRL, 32'd0);
        b = sb.pop_back();
        b.last = 1'b1;
        sb.push_back(b);
        regRead(A_STATUS, rd); checkOutput("abort STATUS draining", rd, 32'h1);
        regRead(A_CTRL, rd);   checkOutput("abort CTRL", rd, 32'h0);
        m_axis_tready = 1'b1;
        waitDrain();
        regRead(A_STATUS, rd); checkOutput("abort STATUS idle", rd, 32'h0);
        regRead(A_BEAT, rd);   checkOutput("abort BEAT_CNT", rd, 32'd1);
        checkOutput("abort no irq", 32'(irqCount), 32'd3);
        for (int i = 0; i < 4; i++) begin
            adc_valid = 1'b1; tick(); adc_valid = 1'b0; tick();
        end
        checkOutput("idle samples ignored", 32'(rxBeats), 32'd1);

        // Start with a packet smaller than one beat, plus read-during-write
        $display("[TB] tiny packet");
        regWrite(A_PKT, 32'd2);
        regWrite(A_CTRL, 32'd3);
        regRead(A_CTRL, rd);   checkOutput("tiny CTRL run 0", rd, 32'h2);
        regRead(A_STATUS, rd); checkOutput("tiny STATUS", rd, 32'h0);
        modelStart(0);
        for (int i = 0; i < 4; i++) begin
            adc_valid = 1'b1; tick(); adc_valid = 1'b0; tick();
        end
        checkOutput("tiny no beats", 32'(rxBeats), 32'd0);
        reg_addr = A_PKT; reg_wdata = 32'h100; reg_wr = 1'b1; reg_rd = 1'b1;
        tick();
        reg_wr = 1'b0; reg_rd = 1'b0;
        checkOutput("read during write", reg_rdata, 32'd2);
        regRead(A_PKT, rd);    checkOutput("PKT_SIZE after write", rd, 32'h100);

        // Reset in the middle of a packet
        $display("[TB] reset mid-packet");
        modelStart(64);
        m_axis_tready = 1'b0;
        regWrite(A_CTRL, 32'd1);
        applyStimulus(12'h000, 1'b0, 1'b0);
        applyStimulus(12'h000, 1'b0, 1'b0);
        checkOutput("pending before reset", 32'(m_axis_tvalid), 32'd1);
        rst = 1'b1;
        tick();
        checkOutput("tvalid after reset", 32'(m_axis_tvalid), 32'd0);
        rst = 1'b0;
        sb.delete();
        m_axis_tready = 1'b1;
        rxBeats = 0;
        regRead(A_CTRL, rd);   checkOutput("post-reset CTRL", rd, 32'd0);
        regRead(A_STATUS, rd); checkOutput("post-reset STATUS", rd, 32'd0);
        regRead(A_PKT, rd);    checkOutput("post-reset PKT_SIZE", rd, 32'd0);
        regRead(A_BEAT, rd);   checkOutput("post-reset BEAT_CNT", rd, 32'd0);
        for (int i = 0; i < 4; i++) begin
            adc_valid = 1'b1; tick(); adc_valid = 1'b0; tick();
        end
        checkOutput("no beats after reset", 32'(rxBeats), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
